trig_cfg_regfile_mc: RTL and testbench

Parametrised, multi-channel trigger-configuration register file for the GP engine. It succeeds the 4-source config regfile and adds:
- NUM_TRIG channels.
- Shadow/active double buffering with an explicit commit.
- A status register.
- Error response on unmapped addresses.
- A proper request/response handshake on the EBB slave side.
- A valid/ack snapshot handshake towards the trigger FSM.

It sits between the EBB slave and the trigger FSM, selected by the address decoder via reg_en.

---
 rtl/trig_cfg_regfile_mc.sv | 214 +++++++++++++++++++++
 tb/tb_trig_cfg_regfile_mc.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_cfg_regfile_mc.sv
// Multi-channel trigger configuration register file: shadow/active double buffering,
// a request/response slave port, and a valid/ack snapshot port towards the trigger FSM.
module trig_cfg_regfile_mc #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          ADDR_WIDTH  = 32,
  parameter int          NUM_TRIG    = 4,
  parameter logic [31:0] CTRL_OFFSET = 32'h80
) (
  input  logic                           i_clk,
  input  logic                           i_rstn,
  input  logic                           reg_en,
  input  logic                           slv_o_valid,
  input  logic                           slv_i_rd0_wr1,
  input  logic [ADDR_WIDTH-1:0]          slv_i_addr,
  input  logic [DATA_WIDTH-1:0]          slv_i_wr_data,
  output logic                           slv_i_ready,
  output logic                           slv_o_rd_valid,
  output logic [DATA_WIDTH-1:0]          slv_o_read_data,
  output logic                           slv_o_err,
  input  logic                           reg_rd_en,
  input  logic                           reg_rd_ack,
  output logic [NUM_TRIG*DATA_WIDTH-1:0] rd_trig_config,
  output logic                           reg_rd_valid
);

  localparam int IDX_W = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1;
  localparam logic [ADDR_WIDTH-1:0] SHADOW_END  = ADDR_WIDTH'(4 * NUM_TRIG);
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR   = ADDR_WIDTH'(CTRL_OFFSET);
  localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(CTRL_OFFSET + 32'd4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RESP = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic                    accept_s;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   data_r;
  logic                    wr_r;
  logic [DATA_WIDTH-1:0]   shadow_r [NUM_TRIG];
  logic [DATA_WIDTH-1:0]   active_r [NUM_TRIG];
  logic [IDX_W-1:0]        idx_s;
  logic                    hit_shadow_s;
  logic                    hit_ctrl_s;
  logic                    hit_status_s;
  logic                    err_s;
  logic                    do_write_s;
  logic [DATA_WIDTH-1:0]   rdata_s;
  logic [DATA_WIDTH-1:0]   status_s;
  logic                    pending_s;
  logic                    any_active_s;
  logic                    snap_s;

  // Slave FSM state register
  always_ff @(posedge i_clk or posedge i_rstn) begin
    if (i_rstn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Slave FSM next state; S_WAIT blocks a still-held request from being taken twice
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (reg_en && slv_o_valid) begin
          state_s  = S_RESP;
          accept_s = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RESP: state_s = S_WAIT;
      S_WAIT: begin
        if (!slv_o_valid) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_WAIT;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Request capture
  always_ff @(posedge i_clk or posedge i_rstn) begin
    if (i_rstn) begin
      addr_r <= {ADDR_WIDTH{1'b0}};
      data_r <= {DATA_WIDTH{1'b0}};
      wr_r   <= 1'b0;
    end else if (accept_s) begin
      addr_r <= slv_i_addr;
      data_r <= slv_i_wr_data;
      wr_r   <= slv_i_rd0_wr1;
    end else begin
      addr_r <= addr_r;
      data_r <= data_r;
      wr_r   <= wr_r;
    end
  end

  // Address decode and error classification of the captured request
  always_comb begin
    idx_s        = addr_r[IDX_W+1:2];
    hit_shadow_s = (addr_r[1:0] == 2'b00) && (addr_r < SHADOW_END);
    hit_ctrl_s   = (addr_r == CTRL_ADDR);
    hit_status_s = (addr_r == STATUS_ADDR);
    err_s        = !(hit_shadow_s || hit_ctrl_s || (hit_status_s && !wr_r));
    do_write_s   = (state_r == S_RESP) && wr_r && !err_s;
  end

  // Status word and the snapshot trigger condition
  always_comb begin
    status_s     = {DATA_WIDTH{1'b0}};
    pending_s    = 1'b0;
    any_active_s = 1'b0;
    for (int i = 0; i < NUM_TRIG; i++) begin
      status_s[i]  = (active_r[i] != {DATA_WIDTH{1'b0}});
      any_active_s = any_active_s | status_s[i];
      pending_s    = pending_s | (shadow_r[i] != active_r[i]);
    end
    status_s[16] = pending_s;
    snap_s       = reg_rd_en && !reg_rd_valid && any_active_s;
  end

  // Read mux; CTRL and faulting reads return zero
  always_comb begin
    rdata_s = {DATA_WIDTH{1'b0}};
    if (hit_shadow_s) begin
      rdata_s = shadow_r[idx_s];
    end else if (hit_status_s) begin
      rdata_s = status_s;
    end else begin
      rdata_s = {DATA_WIDTH{1'b0}};
    end
  end

  // Shadow and active storage; CLEAR takes priority over COMMIT
  always_ff @(posedge i_clk or posedge i_rstn) begin
    if (i_rstn) begin
      for (int i = 0; i < NUM_TRIG; i++) begin
        shadow_r[i] <= {DATA_WIDTH{1'b0}};
        active_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (do_write_s && hit_shadow_s) begin
      shadow_r[idx_s] <= data_r;
    end else if (do_write_s && hit_ctrl_s) begin
      if (data_r[1]) begin
        for (int i = 0; i < NUM_TRIG; i++) begin
          shadow_r[i] <= {DATA_WIDTH{1'b0}};
          active_r[i] <= {DATA_WIDTH{1'b0}};
        end
      end else if (data_r[0]) begin
        for (int i = 0; i < NUM_TRIG; i++) begin
          active_r[i] <= shadow_r[i];
        end
      end else begin
        for (int i = 0; i < NUM_TRIG; i++) begin
          active_r[i] <= active_r[i];
        end
      end
    end else begin
      for (int i = 0; i < NUM_TRIG; i++) begin
        shadow_r[i] <= shadow_r[i];
        active_r[i] <= active_r[i];
      end
    end
  end

  // Slave response pulses; read data only changes on a read response
  always_ff @(posedge i_clk or posedge i_rstn) begin
    if (i_rstn) begin
      slv_i_ready     <= 1'b0;
      slv_o_rd_valid  <= 1'b0;
      slv_o_err       <= 1'b0;
      slv_o_read_data <= {DATA_WIDTH{1'b0}};
    end else begin
      slv_i_ready    <= (state_r == S_RESP) && wr_r;
      slv_o_rd_valid <= (state_r == S_RESP) && !wr_r;
      slv_o_err      <= (state_r == S_RESP) && err_s;
      if ((state_r == S_RESP) && !wr_r) begin
        slv_o_read_data <= rdata_s;
      end else begin
        slv_o_read_data <= slv_o_read_data;
      end
    end
  end

  // Snapshot towards the trigger FSM, held until acknowledged
  always_ff @(posedge i_clk or posedge i_rstn) begin
    if (i_rstn) begin
      reg_rd_valid   <= 1'b0;
      rd_trig_config <= {(NUM_TRIG*DATA_WIDTH){1'b0}};
    end else if (snap_s) begin
      reg_rd_valid <= 1'b1;
      for (int i = 0; i < NUM_TRIG; i++) begin
        rd_trig_config[i*DATA_WIDTH +: DATA_WIDTH] <= active_r[i];
      end
    end else if (reg_rd_valid && reg_rd_ack) begin
      reg_rd_valid   <= 1'b0;
      rd_trig_config <= rd_trig_config;
    end else begin
      reg_rd_valid   <= reg_rd_valid;
      rd_trig_config <= rd_trig_config;
    end
  end

endmodule

// File: tb/tb_trig_cfg_regfile_mc.sv
// Self-checking bench for trig_cfg_regfile_mc: directed scenarios plus random traffic,
// compared every cycle against a transaction-level register map model.
module tb_trig_cfg_regfile_mc;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NT = 4;

  logic            i_clk = 1'b0;
  logic            i_rstn = 1'b1;
  logic            reg_en = 1'b0;
  logic            slv_o_valid = 1'b0;
  logic            slv_i_rd0_wr1 = 1'b0;
  logic [AW-1:0]   slv_i_addr = '0;
  logic [DW-1:0]   slv_i_wr_data = '0;
  logic            slv_i_ready;
  logic            slv_o_rd_valid;
  logic [DW-1:0]   slv_o_read_data;
  logic            slv_o_err;
  logic            reg_rd_en = 1'b0;
  logic            reg_rd_ack = 1'b0;
  logic [NT*DW-1:0] rd_trig_config;
  logic            reg_rd_valid;

  int checks = 0;
  int errors = 0;

  trig_cfg_regfile_mc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_TRIG(NT), .CTRL_OFFSET(32'h80)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .reg_en(reg_en), .slv_o_valid(slv_o_valid),
    .slv_i_rd0_wr1(slv_i_rd0_wr1), .slv_i_addr(slv_i_addr), .slv_i_wr_data(slv_i_wr_data),
    .slv_i_ready(slv_i_ready), .slv_o_rd_valid(slv_o_rd_valid), .slv_o_read_data(slv_o_read_data),
    .slv_o_err(slv_o_err), .reg_rd_en(reg_rd_en), .reg_rd_ack(reg_rd_ack),
    .rd_trig_config(rd_trig_config), .reg_rd_valid(reg_rd_valid)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: register map as arrays, one pending request, one held snapshot
  logic [DW-1:0]    m_shadow [NT];
  logic [DW-1:0]    m_active [NT];
  logic             m_due, m_open, m_wr, m_bad, m_any;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_data, m_rd;
  logic             m_ready, m_rdv, m_err, m_snap_valid;
  logic [DW-1:0]    m_rdata;
  logic [NT*DW-1:0] m_snap;
  int               m_idx;

  function automatic logic [DW-1:0] status_word();
    logic [DW-1:0] s = '0;
    for (int i = 0; i < NT; i++) begin
      if (m_active[i] != '0) s[i] = 1'b1;
      if (m_shadow[i] != m_active[i]) s[16] = 1'b1;
    end
    return s;
  endfunction

  always @(posedge i_clk or posedge i_rstn) begin
    if (i_rstn) begin
      for (int i = 0; i < NT; i++) begin
        m_shadow[i] = '0;
        m_active[i] = '0;
      end
      m_due = 0; m_open = 0; m_ready = 0; m_rdv = 0; m_err = 0;
      m_rdata = '0; m_snap_valid = 0; m_snap = '0;
    end else begin
      m_any = 0;
      for (int i = 0; i < NT; i++) m_any = m_any | (m_active[i] != '0);
      if (!m_snap_valid && reg_rd_en && m_any) begin
        for (int i = 0; i < NT; i++) m_snap[i*DW +: DW] = m_active[i];
        m_snap_valid = 1;
      end else if (m_snap_valid && reg_rd_ack) begin
        m_snap_valid = 0;
      end
      m_ready = 0; m_rdv = 0; m_err = 0;
      if (m_due) begin
        m_bad = 1; m_rd = '0;
        m_idx = int'(m_addr >> 2);
        if (m_addr % 4 == 0 && m_addr < 4 * NT) begin
          m_bad = 0;
          if (m_wr) m_shadow[m_idx] = m_data;
          else m_rd = m_shadow[m_idx];
        end else if (m_addr == 32'h80) begin
          m_bad = 0;
          if (m_wr && m_data[1]) begin
            for (int i = 0; i < NT; i++) begin m_shadow[i] = '0; m_active[i] = '0; end
          end else if (m_wr && m_data[0]) begin
            for (int i = 0; i < NT; i++) m_active[i] = m_shadow[i];
          end
        end else if (m_addr == 32'h84 && !m_wr) begin
          m_bad = 0;
          m_rd = status_word();
        end
        if (m_wr) m_ready = 1;
        else begin m_rdv = 1; m_rdata = m_rd; end
        m_err = m_bad;
        m_due = 0;
      end else if (m_open) begin
        if (!slv_o_valid) m_open = 0;
      end else if (reg_en && slv_o_valid) begin
        m_addr = slv_i_addr; m_data = slv_i_wr_data; m_wr = slv_i_rd0_wr1;
        m_due = 1; m_open = 1;
      end
    end
  end

  always @(negedge i_clk) begin
    if (!i_rstn) begin
      chk("ready", slv_i_ready, m_ready);
      chk("rd_valid", slv_o_rd_valid, m_rdv);
      chk("err", slv_o_err, m_err);
      chk("read_data", slv_o_read_data, m_rdata);
      chk("snap_valid", reg_rd_valid, m_snap_valid);
      chk("snap_data", rd_trig_config, m_snap);
    end
  end

  task automatic xact(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output logic [DW-1:0] rd, output logic er);
    bit got = 0;
    rd = '0; er = 1'b0;
    @(posedge i_clk); #1;
    reg_en = 1'b1; slv_o_valid = 1'b1; slv_i_rd0_wr1 = wr; slv_i_addr = a; slv_i_wr_data = d;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge i_clk);
      if (slv_i_ready || slv_o_rd_valid) begin
        got = 1; rd = slv_o_read_data; er = slv_o_err;
      end
    end
    if (!got) chk("resp_timeout", 1'b0, 1'b1);
    slv_o_valid = 1'b0; reg_en = 1'b0;
  endtask

  task automatic pulse_rd_en();
    @(posedge i_clk); #1 reg_rd_en = 1'b1;
    @(posedge i_clk); #1 reg_rd_en = 1'b0;
  endtask

  logic [DW-1:0] rd;
  logic          er;
  int            pulses;
  bit            rand_done;
  int            pick;
  logic [AW-1:0] ra;
  logic [DW-1:0] rdat;

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ready", slv_i_ready, 1'b0);
    chk("rst_rdv", slv_o_rd_valid, 1'b0);
    chk("rst_rdata", slv_o_read_data, 32'h0);
    chk("rst_snapv", reg_rd_valid, 1'b0);
    chk("rst_snap", rd_trig_config, 128'h0);
    @(negedge i_clk) i_rstn = 1'b0;

    // all-zero configs never produce a snapshot
    reg_rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      chk("zero_nosnap", reg_rd_valid, 1'b0);
    end
    reg_rd_en = 1'b0;

    xact(1'b1, 32'h0, 32'hA5A5_0001, rd, er);  chk("wr0_err", er, 1'b0);
    xact(1'b0, 32'h0, 32'h0, rd, er);          chk("rd0_data", rd, 32'hA5A5_0001); chk("rd0_err", er, 1'b0);
    xact(1'b0, 32'h84, 32'h0, rd, er);         chk("status_pending", rd, 32'h0001_0000);

    xact(1'b1, 32'h80, 32'h1, rd, er);
    xact(1'b0, 32'h84, 32'h0, rd, er);         chk("status_commit", rd, 32'h0000_0001);
    pulse_rd_en();
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("snap_held_v", reg_rd_valid, 1'b1);
      chk("snap_held_d", rd_trig_config[31:0], 32'hA5A5_0001);
    end
    @(posedge i_clk); #1 reg_rd_ack = 1'b1;
    @(posedge i_clk); #1 reg_rd_ack = 1'b0;
    @(negedge i_clk);
    chk("snap_acked", reg_rd_valid, 1'b0);

    xact(1'b0, 32'h44, 32'h0, rd, er);         chk("unmapped_err", er, 1'b1);
    xact(1'b1, 32'h2, 32'hFFFF_FFFF, rd, er);  chk("unaligned_err", er, 1'b1);
    xact(1'b1, 32'h84, 32'hFFFF_FFFF, rd, er); chk("wr_status_err", er, 1'b1);
    xact(1'b0, 32'h0, 32'h0, rd, er);          chk("unchanged", rd, 32'hA5A5_0001);
    xact(1'b0, 32'h80, 32'h0, rd, er);         chk("ctrl_rd", rd, 32'h0); chk("ctrl_rd_err", er, 1'b0);

    // held write request is answered exactly once
    pulses = 0;
    @(posedge i_clk); #1;
    reg_en = 1'b1; slv_o_valid = 1'b1; slv_i_rd0_wr1 = 1'b1; slv_i_addr = 32'h4; slv_i_wr_data = 32'h1234;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      if (slv_i_ready) pulses++;
    end
    slv_o_valid = 1'b0; reg_en = 1'b0;
    chk("hold_once", pulses, 1);
    xact(1'b0, 32'h4, 32'h0, rd, er);          chk("hold_rd", rd, 32'h1234);

    rand_done = 0;
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          pick = $urandom_range(0, 7);
          rdat = $urandom;
          case (pick)
            0, 1, 2, 3: ra = 32'(4 * pick);
            4: begin ra = 32'h80; rdat = 32'($urandom_range(0, 3)); end
            5: ra = 32'h84;
            6: ra = ($urandom % 2 == 0) ? 32'h44 : 32'h100;
            default: ra = 32'(4 * $urandom_range(0, 3) + $urandom_range(1, 3));
          endcase
          xact(1'($urandom % 2), ra, rdat, rd, er);
          repeat ($urandom_range(0, 2)) @(posedge i_clk);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge i_clk); #1;
          reg_rd_en = ($urandom % 4) != 0;
          reg_rd_ack = ($urandom % 3) == 0;
        end
        reg_rd_en = 1'b0; reg_rd_ack = 1'b0;
      end
    join

    // reset in the middle of a response and of a held snapshot
    @(posedge i_clk); #1 reg_rd_ack = 1'b1;
    @(posedge i_clk); #1 reg_rd_ack = 1'b0;
    xact(1'b1, 32'h0, 32'hDEAD_0001, rd, er);
    xact(1'b1, 32'h80, 32'h1, rd, er);
    pulse_rd_en();
    xact(1'b0, 32'h0, 32'h0, rd, er);          chk("pre_rst_rd", rd, 32'hDEAD_0001);
    chk("pre_rst_snapv", reg_rd_valid, 1'b1);
    @(posedge i_clk); #1;
    reg_en = 1'b1; slv_o_valid = 1'b1; slv_i_rd0_wr1 = 1'b1; slv_i_addr = 32'h8; slv_i_wr_data = 32'h77;
    @(posedge i_clk); #2;
    i_rstn = 1'b1;
    #1;
    chk("mid_rst_ready", slv_i_ready, 1'b0);
    chk("mid_rst_err", slv_o_err, 1'b0);
    chk("mid_rst_rdata", slv_o_read_data, 32'h0);
    chk("mid_rst_snapv", reg_rd_valid, 1'b0);
    chk("mid_rst_snap", rd_trig_config, 128'h0);
    slv_o_valid = 1'b0; reg_en = 1'b0;
    @(negedge i_clk) i_rstn = 1'b0;
    xact(1'b0, 32'h8, 32'h0, rd, er);          chk("dropped_wr", rd, 32'h0);
    xact(1'b0, 32'h0, 32'h0, rd, er);          chk("rst_cleared", rd, 32'h0);

    // commit and clear together: clear wins
    xact(1'b1, 32'h0, 32'h5, rd, er);
    xact(1'b1, 32'h4, 32'h6, rd, er);
    xact(1'b1, 32'h80, 32'h1, rd, er);
    xact(1'b0, 32'h84, 32'h0, rd, er);         chk("status_two", rd, 32'h3);
    xact(1'b1, 32'h80, 32'h3, rd, er);
    xact(1'b0, 32'h84, 32'h0, rd, er);         chk("status_cleared", rd, 32'h0);
    xact(1'b0, 32'h4, 32'h0, rd, er);          chk("shadow_cleared", rd, 32'h0);
    reg_rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      chk("cleared_nosnap", reg_rd_valid, 1'b0);
    end
    reg_rd_en = 1'b0;
    repeat (3) @(posedge i_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
